seq_divider: RTL

Sequential unsigned restoring divider that takes a 2N-bit dividend and an N-bit divisor and produces an N-bit quotient and an N-bit remainder. It retires one quotient bit per clock. It is the inverse companion of the datapath's 8x8 array multiplier: any 16-bit product plus a remainder smaller than the divisor divides back to the original operands. Software or a controlling FSM drives it with a start/done handshake.

---
 rtl/seq_divider.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
//
// Divides a 2N-bit dividend by an N-bit divisor. The quotient and remainder are N bits wide.
// A request is accepted on start while the unit is idle or just completing.
// Divide-by-zero and quotient overflow are detected when the request is accepted.
// In those cases the unit completes in one cycle without iterating.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request a division (ignored while busy)
//   dividend     2N-bit unsigned dividend, sampled on acceptance
//   divisor      N-bit unsigned divisor, sampled on acceptance
//   busy         high while iterating
//   done         one-cycle completion pulse; results/flags valid while high
//   quotient     N-bit quotient, held until the next completion
//   remainder    N-bit remainder, held until the next completion
//   div_by_zero  divisor was zero (held with results)
//   overflow     true quotient exceeded N bits (held with results)
module seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;          // partial remainder, always < divisor
    logic [N-1:0]  lo_q, lo_d;            // low dividend bits still to consume, MSB first
    logic [N-1:0]  quo_q, quo_d;          // quotient bits collected so far
    logic [N-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic [N:0]    trial;
    logic [N-1:0]  diff;
    logic          qbit;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        accept = start && (state_q != StCalc);
        trial  = {rem_q, lo_q[N-1]};
        qbit   = (trial >= {1'b0, dsr_q});
        // The true difference is below the divisor, so modulo-2^N subtraction is exact.
        diff   = trial[N-1:0] - dsr_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    dsr_d = divisor;
                    lo_d  = dividend[N-1:0];
                    rem_d = dividend[2*N-1:N];
                    quo_d = '0;
                    cnt_d = CW'(N);
                    if (divisor == '0) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = qbit ? diff : trial[N-1:0];
                lo_d  = lo_q << 1;
                quo_d = (quo_q << 1) | N'(qbit);
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = StDone;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            lo_q        <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = (state_q == StCalc);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
